// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl -- multiplexed 8-digit seven-segment scan controller.
//
// Each digit is scanned in four phases. BLANK turns every anode off and
// SETTLE waits while the external digit mux follows the new light index.
// LATCH captures num/dot into the segment registers. SHOW then drives the
// selected anode for SCAN_DIV cycles.
//
// Optional feature macro: DISP_BLINK_EN. When it is defined, a frame counter
// and a blink phase suppress the anode of any digit whose blink_mask bit is
// set, during every other group of BLINK_FRAMES frames.
//
// Parameters
//   SCAN_DIV     SHOW dwell per digit in clk cycles (>= 2)
//   SETTLE_CYC   cycles allowed for the digit mux to settle (>= 1)
//   BLINK_FRAMES full frames per blink half-period (>= 1)
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable; low blanks the display and holds light
//   num[10:0]   in   digit code: 0-9 digit, 11 dash, anything else blank
//   dot         in   decimal point for the current light, active-high
//   blink_mask  in   per-digit blink request (ignored without DISP_BLINK_EN)
//   light[2:0]  out  digit index presented to the digit mux
//   an[7:0]     out  anode enables, active-low
//   seg[6:0]    out  segments g..a, active-low (seg[0] = a)
//   dp          out  decimal point, active-low
//   frame_done  out  one-cycle pulse after digit 7's SHOW period ends
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int SETTLE_CYC   = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] num,
    input  logic        dot,
    input  logic [7:0]  blink_mask,
    output logic [2:0]  light,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int TW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SETTLE = 2'd1,
        LATCH  = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t         state, next_state;
    logic [SW-1:0]  scan_cnt;
    logic [TW-1:0]  settle_cnt;
    logic           scan_last;
    logic           settle_last;
    logic           blink_off;

    assign scan_last   = (scan_cnt == SW'(SCAN_DIV - 1));
    assign settle_last = (settle_cnt == TW'(SETTLE_CYC - 1));

    // Active-low decode, bit order g..a.
    function automatic logic [6:0] decode(input logic [10:0] code);
        logic [6:0] s;
        case (code)
            11'd0:   s = 7'h40;
            11'd1:   s = 7'h79;
            11'd2:   s = 7'h24;
            11'd3:   s = 7'h30;
            11'd4:   s = 7'h19;
            11'd5:   s = 7'h12;
            11'd6:   s = 7'h02;
            11'd7:   s = 7'h78;
            11'd8:   s = 7'h00;
            11'd9:   s = 7'h10;
            11'd11:  s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BLANK;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!en) begin
            // en takes priority over every transition, including a SHOW
            // terminal count.
            next_state = BLANK;
        end else begin
            case (state)
                BLANK:   next_state = SETTLE;
                SETTLE:  if (settle_last) next_state = LATCH;
                LATCH:   next_state = SHOW;
                SHOW:    if (scan_last) next_state = BLANK;
                default: next_state = BLANK;
            endcase
        end
    end

    // ---------------- counters, light, frame pulse ----------------
    // Both counters sit at zero outside their own state. The prescaler is
    // therefore already clear on SHOW entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            scan_cnt   <= '0;
            light      <= 3'd0;
            frame_done <= 1'b0;
        end else if (!en) begin
            settle_cnt <= '0;
            scan_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            settle_cnt <= (state == SETTLE && !settle_last) ? settle_cnt + 1'b1 : '0;
            scan_cnt   <= (state == SHOW && !scan_last) ? scan_cnt + 1'b1 : '0;
            frame_done <= (state == SHOW) && scan_last && (light == 3'd7);
            if (state == SHOW && scan_last)
                light <= light + 3'd1;
        end
    end

    // ---------------- segment / dp registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (en && state == LATCH) begin
            seg <= decode(num);
            dp  <= ~dot;
        end
    end

    // ---------------- optional blink ----------------
`ifdef DISP_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [FW-1:0] frame_cnt;
    logic          phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_done) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Only the anode is suppressed. Scan timing is unchanged.
    assign blink_off = phase & blink_mask[light];
`else
    logic unused_blink;
    assign unused_blink = &{1'b0, blink_mask};
    assign blink_off    = 1'b0;
`endif

    // ---------------- anode drive ----------------
    always_comb begin
        an = 8'hFF;
        if (state == SHOW && !blink_off)
            an = ~(8'(8'b1 << light));
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_DIV=4, SETTLE_CYC=2 and
// BLINK_FRAMES=2, giving a digit pitch of 8 cycles and a frame of 64 cycles.
// kN marks the sample point #1 after rising edge N. Edge 1 is the first edge
// after reset release.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] num;
    logic        dot;
    logic [7:0]  blink_mask;
    logic [2:0]  light;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    logic [10:0] num_man;
    logic        follow;
    int          vectors = 0;
    int          miscompares = 0;

    // The digit mux model: either a fixed code, or the light index itself.
    assign num = follow ? {8'd0, light} : num_man;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.SCAN_DIV(4), .SETTLE_CYC(2), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .num(num), .dot(dot),
        .blink_mask(blink_mask), .light(light), .an(an), .seg(seg),
        .dp(dp), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; num_man = 11'd8; dot = 1'b0;
        blink_mask = 8'h00; follow = 1'b0;
        tick(2);
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_light", light, 3'd0);
        rst_n = 1'b1;

        tick(1);  chk("k1_an", an, 8'hFF);                 // SETTLE
        tick(2);  chk("k3_an", an, 8'hFF);                 // LATCH
        tick(1);  chk("k4_an", an, 8'hFE);                 // SHOW digit 0
                  chk("k4_seg", seg, 7'h00);
                  chk("k4_dp", dp, 1'b1);
                  chk("k4_light", light, 3'd0);
        tick(3);  chk("k7_an", an, 8'hFE);
        tick(1);  chk("k8_an", an, 8'hFF);                 // BLANK digit 1
                  chk("k8_light", light, 3'd1);
        num_man = 11'd11; dot = 1'b1;
        tick(4);  chk("k12_an", an, 8'hFD);
                  chk("k12_dash", seg, 7'h3F);
                  chk("k12_dp", dp, 1'b0);
        num_man = 11'd12; dot = 1'b0;
        tick(8);  chk("k20_an", an, 8'hFB);
                  chk("k20_blank", seg, 7'h7F);
                  chk("k20_dp", dp, 1'b1);
        follow = 1'b1;
        tick(8);  chk("k28_an", an, 8'hF7);
                  chk("k28_seg3", seg, 7'h30);
                  chk("k28_light", light, 3'd3);
        tick(1);  en = 1'b0;                               // mid SHOW digit 3
        tick(1);  chk("en_off_an", an, 8'hFF);
                  chk("en_off_light", light, 3'd3);
        tick(9);  chk("en_hold_an", an, 8'hFF);
                  chk("en_hold_light", light, 3'd3);
                  chk("en_hold_fd", frame_done, 1'b0);
        en = 1'b1;
        tick(3);  chk("resume_k42_an", an, 8'hFF);
        tick(1);  chk("resume_an", an, 8'hF7);
                  chk("resume_seg", seg, 7'h30);
                  chk("resume_light", light, 3'd3);
        tick(8);  chk("d4_an", an, 8'hEF);  chk("d4_seg", seg, 7'h19);
        tick(8);  chk("d5_an", an, 8'hDF);  chk("d5_seg", seg, 7'h12);
        tick(8);  chk("d6_an", an, 8'hBF);  chk("d6_seg", seg, 7'h02);
        tick(8);  chk("d7_an", an, 8'h7F);  chk("d7_seg", seg, 7'h78);
                  chk("d7_light", light, 3'd7);
        tick(3);  chk("d7_end_an", an, 8'h7F);
                  chk("d7_end_fd", frame_done, 1'b0);
        tick(1);  chk("wrap_fd", frame_done, 1'b1);        // k79
                  chk("wrap_light", light, 3'd0);
                  chk("wrap_an", an, 8'hFF);
        tick(1);  chk("fd_single", frame_done, 1'b0);
        blink_mask = 8'h01;
        tick(3);  chk("f1_d0_an", an, 8'hFE);              // frame 1, phase 0
                  chk("f1_d0_seg", seg, 7'h40);
        tick(60); chk("f1_wrap_fd", frame_done, 1'b1);     // k143
        tick(4);                                           // frame 2 digit 0 SHOW
`ifdef DISP_BLINK_EN
        chk("f2_d0_blink_an", an, 8'hFF);
`else
        chk("f2_d0_an", an, 8'hFE);
`endif
        chk("f2_d0_light", light, 3'd0);
        tick(8);  chk("f2_d1_an", an, 8'hFD);              // unmasked digit
        tick(29); chk("d5_settle_an", an, 8'hFF);          // k184, SETTLE digit 5
                  chk("d5_settle_light", light, 3'd5);
        rst_n = 1'b0;
        #1;
        chk("arst_an", an, 8'hFF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_dp", dp, 1'b1);
        chk("arst_light", light, 3'd0);
        chk("arst_fd", frame_done, 1'b0);
        tick(1);  rst_n = 1'b1;
        tick(1);  chk("post_rst_k186_an", an, 8'hFF);
        tick(2);  chk("post_rst_k188_an", an, 8'hFF);
        tick(1);  chk("post_rst_an", an, 8'hFE);
                  chk("post_rst_light", light, 3'd0);
                  chk("post_rst_seg", seg, 7'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
